// File: rtl/sal_bank_cmd_arbiter_pkg.sv
// sal_ddr2_pkg: DDR2 command codes, default timing and bank geometry
// shared by the bank command arbiter and its helpers.
package sal_ddr2_pkg;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } cmd_e;

    localparam int DDR2_BANKS  = 8;
    localparam int DDR2_BA_W   = $clog2(DDR2_BANKS);
    localparam int DDR2_ADDR_W = 14;

    localparam int T_RRD_DEF = 2;
    localparam int T_CCD_DEF = 2;
    localparam int T_WTR_DEF = 3;
    localparam int T_RTW_DEF = 4;

    localparam int CNT_W = 4;

    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

    function automatic logic is_cas(input logic [2:0] c);
        return (c == CMD_RD) || (c == CMD_WR);
    endfunction

endpackage

// File: rtl/sal_bank_cmd_arbiter_if.sv
// Bank-request / refresh handshake and DDR2 command bus bundle.
// master = bank controller side, slave = arbiter side.
interface sal_bank_cmd_arbiter_if #(
    parameter int BK_CNT = 8,
    parameter int ADDR_W = 14
);
    localparam int BA_W = (BK_CNT > 1) ? $clog2(BK_CNT) : 1;

    logic [BK_CNT-1:0]        req_valid;
    logic [BK_CNT*3-1:0]      req_cmd;
    logic [BK_CNT*ADDR_W-1:0] req_addr;
    logic [BK_CNT-1:0]        req_ready;
    logic                     ref_req;
    logic                     ref_ack;
    logic                     cmd_valid;
    logic [2:0]               cmd_code;
    logic [BA_W-1:0]          cmd_ba;
    logic [ADDR_W-1:0]        cmd_addr;

    modport master (
        output req_valid, req_cmd, req_addr, ref_req,
        input  req_ready, ref_ack,
        input  cmd_valid, cmd_code, cmd_ba, cmd_addr
    );

    modport slave (
        input  req_valid, req_cmd, req_addr, ref_req,
        output req_ready, ref_ack,
        output cmd_valid, cmd_code, cmd_ba, cmd_addr
    );

endinterface

// File: rtl/sal_bank_cmd_arbiter_rr.sv
// sal_rr_arbiter: rotating-priority picker, first eligible
// requester at or after ptr (wrapping) wins.
module sal_rr_arbiter #(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    int   j;
    logic found;

    // scan N positions starting at ptr, keep the first hit
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!found && elig[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/sal_bank_cmd_arbiter.sv
// sal_bank_cmd_arbiter: shares the DDR2 command bus among bank controllers.
// Optional macro SAL_ARB_CAS_PRIO_EN: RD/WR tier beats ACT/PRE tier.
import sal_ddr2_pkg::*;

module sal_bank_cmd_arbiter #(
    parameter int BK_CNT = DDR2_BANKS,
    parameter int ADDR_W = DDR2_ADDR_W,
    parameter int T_RRD  = T_RRD_DEF,
    parameter int T_CCD  = T_CCD_DEF,
    parameter int T_WTR  = T_WTR_DEF,
    parameter int T_RTW  = T_RTW_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sal_bank_cmd_arbiter_if.slave  bus
);

    localparam int BA_W = (BK_CNT > 1) ? $clog2(BK_CNT) : 1;

    typedef enum logic {ST_ARB, ST_REF_WAIT} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  rrd_q, ccd_q, wtr_q, rtw_q;
    logic [BA_W-1:0]   rr_ptr_q;
    logic [2:0]        bank_cmd [BK_CNT];
    logic [BK_CNT-1:0] elig;
    logic [BK_CNT-1:0] grant;
    logic [BA_W-1:0]   win_idx;
    logic [2:0]        win_cmd;
    logic [ADDR_W-1:0] win_addr;
    logic              cnt_zero;
    logic              bank_fire;

    assign cnt_zero = (rrd_q == '0) && (ccd_q == '0)
                   && (wtr_q == '0) && (rtw_q == '0);

    // per-bank eligibility against the shared timing counters
    always_comb begin
        elig = '0;
        for (int i = 0; i < BK_CNT; i++) begin
            bank_cmd[i] = bus.req_cmd[i*3 +: 3];
            if (bus.req_valid[i]) begin
                case (bank_cmd[i])
                    CMD_ACT: elig[i] = (rrd_q == '0);
                    CMD_RD:  elig[i] = (ccd_q == '0) && (wtr_q == '0);
                    CMD_WR:  elig[i] = (ccd_q == '0) && (rtw_q == '0);
                    CMD_PRE: elig[i] = 1'b1;
                    default: elig[i] = 1'b0;
                endcase
            end
        end
    end

`ifdef SAL_ARB_CAS_PRIO_EN
    logic [BK_CNT-1:0] cas_v, gnt_hi, gnt_lo;
    logic [BA_W-1:0]   idx_hi, idx_lo;

    // split requests into the column tier and the row tier
    always_comb begin
        cas_v = '0;
        for (int i = 0; i < BK_CNT; i++) begin
            cas_v[i] = is_cas(bank_cmd[i]);
        end
    end

    sal_rr_arbiter #(.N(BK_CNT), .IW(BA_W)) u_rr_hi (
        .elig (elig & cas_v),
        .ptr  (rr_ptr_q),
        .gnt  (gnt_hi),
        .idx  (idx_hi)
    );

    sal_rr_arbiter #(.N(BK_CNT), .IW(BA_W)) u_rr_lo (
        .elig (elig & ~cas_v),
        .ptr  (rr_ptr_q),
        .gnt  (gnt_lo),
        .idx  (idx_lo)
    );

    assign grant   = (|gnt_hi) ? gnt_hi : gnt_lo;
    assign win_idx = (|gnt_hi) ? idx_hi : idx_lo;
`else
    sal_rr_arbiter #(.N(BK_CNT), .IW(BA_W)) u_rr (
        .elig (elig),
        .ptr  (rr_ptr_q),
        .gnt  (grant),
        .idx  (win_idx)
    );
`endif

    assign win_cmd  = bank_cmd[win_idx];
    assign win_addr = bus.req_addr[win_idx*ADDR_W +: ADDR_W];

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_ARB;
        else        state_q <= state_d;
    end

    // FSM next state: wait for refresh until acked or withdrawn
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARB:
                if (bus.ref_req && !bus.ref_ack) state_d = ST_REF_WAIT;
            ST_REF_WAIT:
                if (bus.ref_ack || !bus.ref_req) state_d = ST_ARB;
            default: state_d = ST_ARB;
        endcase
    end

    // FSM outputs: refresh owns the bus, banks see no ready
    always_comb begin
        bus.ref_ack   = rst_n && bus.ref_req && cnt_zero;
        bus.req_ready = '0;
        if (rst_n && !bus.ref_req) bus.req_ready = grant;
    end

    assign bank_fire = |bus.req_ready;

    // timing counters: reload on grant of their class, else count down
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrd_q <= '0;
            ccd_q <= '0;
            wtr_q <= '0;
            rtw_q <= '0;
        end else if (bus.ref_ack) begin
            rrd_q <= '0;
            ccd_q <= '0;
            wtr_q <= '0;
            rtw_q <= '0;
        end else begin
            rrd_q <= (bank_fire && win_cmd == CMD_ACT)
                   ? CNT_W'(T_RRD - 1) : sat_dec(rrd_q);
            ccd_q <= (bank_fire && is_cas(win_cmd))
                   ? CNT_W'(T_CCD - 1) : sat_dec(ccd_q);
            wtr_q <= (bank_fire && win_cmd == CMD_WR)
                   ? CNT_W'(T_WTR - 1) : sat_dec(wtr_q);
            rtw_q <= (bank_fire && win_cmd == CMD_RD)
                   ? CNT_W'(T_RTW - 1) : sat_dec(rtw_q);
        end
    end

    // round-robin pointer advances past each bank winner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else if (bank_fire) begin
            if (win_idx == BA_W'(BK_CNT - 1)) rr_ptr_q <= '0;
            else                              rr_ptr_q <= win_idx + 1'b1;
        end
    end

    // registered command bus; ba/addr hold across NOP cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.cmd_valid <= 1'b0;
            bus.cmd_code  <= CMD_NOP;
            bus.cmd_ba    <= '0;
            bus.cmd_addr  <= '0;
        end else if (bus.ref_ack) begin
            bus.cmd_valid <= 1'b1;
            bus.cmd_code  <= CMD_REF;
        end else if (bank_fire) begin
            bus.cmd_valid <= 1'b1;
            bus.cmd_code  <= win_cmd;
            bus.cmd_ba    <= win_idx;
            bus.cmd_addr  <= win_addr;
        end else begin
            bus.cmd_valid <= 1'b0;
            bus.cmd_code  <= CMD_NOP;
        end
    end

endmodule
